// File: rtl/fifo_ptr_ctrl_if.sv
// Request/status bundle between a buffer owner and fifo_ptr_ctrl.
// The master issues Clear/Push/Pop. The controller (slave) returns pointers,
// strobes and status flags.
interface fifo_ptr_ctrl_if #(
  parameter int BufferWidth = 4
);
  logic                   Clear;
  logic                   Push;
  logic                   Pop;
  logic [BufferWidth-1:0] W_Addr;
  logic [BufferWidth-1:0] R_Addr;
  logic                   WE;
  logic                   RE;
  logic                   Round;
  logic                   Full;
  logic                   Empty;
  logic [BufferWidth:0]   Count;
  logic                   AlmostFull;
  logic                   AlmostEmpty;
  logic                   Overflow;
  logic                   Underflow;

  modport master (
    output Clear, Push, Pop,
    input  W_Addr, R_Addr, WE, RE, Round, Full, Empty, Count,
           AlmostFull, AlmostEmpty, Overflow, Underflow
  );

  modport slave (
    input  Clear, Push, Pop,
    output W_Addr, R_Addr, WE, RE, Round, Full, Empty, Count,
           AlmostFull, AlmostEmpty, Overflow, Underflow
  );
endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Pointer/status controller for a single-clock circular buffer.
// It tracks the write and read pointers and a lap bit (Round), which
// disambiguates full from empty when the two pointers are equal.
// WE and RE are the gated memory strobes, so rejected requests never
// touch storage.
module fifo_ptr_ctrl #(
  parameter int BufferWidth    = 4,
  parameter int AlmostFullLvl  = 12,
  parameter int AlmostEmptyLvl = 2
) (
  input  logic           clk,
  input  logic           rst,
  fifo_ptr_ctrl_if.slave bus
);
  localparam int                     DEPTH    = 1 << BufferWidth;
  localparam logic [BufferWidth-1:0] LAST_IDX = BufferWidth'(DEPTH - 1);
  localparam logic [BufferWidth-1:0] PTR_ONE  = BufferWidth'(1);
  localparam logic [BufferWidth:0]   CNT_ONE  = (BufferWidth+1)'(1);
  localparam logic [BufferWidth:0]   DEPTH_C  = (BufferWidth+1)'(DEPTH);
  localparam logic [BufferWidth:0]   AF_LVL   = (BufferWidth+1)'(AlmostFullLvl);
  localparam logic [BufferWidth:0]   AE_LVL   = (BufferWidth+1)'(AlmostEmptyLvl);

  logic [BufferWidth-1:0] w_ptr, r_ptr;
  logic [BufferWidth:0]   count_q;
  logic                   round_q, ovf_q, udf_q;

  logic ptr_eq, full, empty;
  logic we, re, w_wrap, r_wrap, ovf_set, udf_set;

  // Full/empty come from registered state only. Equal pointers are resolved
  // by the lap bit.
  assign ptr_eq = (w_ptr == r_ptr);
  assign full   = ptr_eq &&  round_q;
  assign empty  = ptr_eq && !round_q;

  // Acceptance rules:
  // - A pop frees a slot, so push-on-full is accepted when paired with a pop.
  // - There is no read-through, so pop-on-empty is always rejected.
  // - Clear masks both strobes.
  assign we = !bus.Clear && bus.Push && (!full || bus.Pop);
  assign re = !bus.Clear && bus.Pop  && !empty;

  // A pointer wraps when it advances from the last index.
  // Round flips only when exactly one pointer wraps.
  assign w_wrap = we && (w_ptr == LAST_IDX);
  assign r_wrap = re && (r_ptr == LAST_IDX);

  assign ovf_set = bus.Push && full && !bus.Pop;
  assign udf_set = bus.Pop  && empty;

  // Pointer, lap, occupancy and sticky-error state.
  // Clear returns everything to the reset state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      round_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else if (bus.Clear) begin
      w_ptr   <= '0;
      r_ptr   <= '0;
      round_q <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      if (we)              w_ptr   <= w_ptr + PTR_ONE;
      if (re)              r_ptr   <= r_ptr + PTR_ONE;
      if (w_wrap ^ r_wrap) round_q <= ~round_q;
      case ({we, re})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
      if (ovf_set) ovf_q <= 1'b1;
      if (udf_set) udf_q <= 1'b1;
    end
  end

  assign bus.W_Addr      = w_ptr;
  assign bus.R_Addr      = r_ptr;
  assign bus.WE          = we;
  assign bus.RE          = re;
  assign bus.Round       = round_q;
  assign bus.Full        = full;
  assign bus.Empty       = empty;
  assign bus.Count       = count_q;
  assign bus.AlmostFull  = (count_q >= AF_LVL);
  assign bus.AlmostEmpty = (count_q <= AE_LVL);
  assign bus.Overflow    = ovf_q;
  assign bus.Underflow   = udf_q;

  // Structural invariants of the pointer/lap encoding.
  a_full_empty_excl: assert property (@(posedge clk) disable iff (!rst)
    !(full && empty));
  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    count_q <= DEPTH_C);
  a_count_ptrs: assert property (@(posedge clk) disable iff (!rst)
    count_q == ({1'b0, w_ptr - r_ptr} + (full ? DEPTH_C : '0)));
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl.
// It applies a vector table, hand sequences for the wrap/flag corners, and
// random traffic. The reference model keeps only lifetime push/pop totals
// and derives every output from them.
module tb_fifo_ptr_ctrl;
  localparam int BW    = 4;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int AEL   = 2;

  logic clk;
  logic rst;
  fifo_ptr_ctrl_if #(.BufferWidth(BW)) bus();

  fifo_ptr_ctrl #(.BufferWidth(BW), .AlmostFullLvl(AFL), .AlmostEmptyLvl(AEL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Model state: lifetime accepted pushes/pops plus the sticky flags.
  int m_push, m_pop;
  bit m_ovf, m_udf;

  function automatic int m_cnt();
    return m_push - m_pop;
  endfunction

  task automatic model_reset();
    m_push = 0; m_pop = 0; m_ovf = 0; m_udf = 0;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // Registered outputs vs. the model.
  // Round is set when the writer has completed one more lap than the reader.
  task automatic chk_state(input string tag);
    chk({tag, ".w_addr"}, int'(bus.W_Addr), m_push % DEPTH);
    chk({tag, ".r_addr"}, int'(bus.R_Addr), m_pop % DEPTH);
    chk({tag, ".count"},  int'(bus.Count),  m_cnt());
    chk({tag, ".round"},  int'(bus.Round),  ((m_push / DEPTH) - (m_pop / DEPTH)) == 1 ? 1 : 0);
    chk({tag, ".full"},   int'(bus.Full),   m_cnt() == DEPTH ? 1 : 0);
    chk({tag, ".empty"},  int'(bus.Empty),  m_cnt() == 0 ? 1 : 0);
    chk({tag, ".afull"},  int'(bus.AlmostFull),  m_cnt() >= AFL ? 1 : 0);
    chk({tag, ".aempty"}, int'(bus.AlmostEmpty), m_cnt() <= AEL ? 1 : 0);
    chk({tag, ".ovf"},    int'(bus.Overflow),  int'(m_ovf));
    chk({tag, ".udf"},    int'(bus.Underflow), int'(m_udf));
  endtask

  // One cycle:
  // - drive the inputs on the falling edge;
  // - check the combinational strobes before the rising edge;
  // - advance the model and check the registered state after the rising edge.
  task automatic step(input bit c, input bit p, input bit q, input string tag,
                      output bit s_we, output bit s_re);
    bit e_we, e_re;
    @(negedge clk);
    bus.Clear = c; bus.Push = p; bus.Pop = q;
    #1;
    e_re = !c && q && (m_cnt() > 0);
    e_we = !c && p && (m_cnt() < DEPTH || q);
    s_we = bus.WE;
    s_re = bus.RE;
    chk({tag, ".we"}, int'(s_we), int'(e_we));
    chk({tag, ".re"}, int'(s_re), int'(e_re));
    @(posedge clk);
    #1;
    if (c) model_reset();
    else begin
      if (p && m_cnt() == DEPTH && !q) m_ovf = 1;
      if (q && m_cnt() == 0)           m_udf = 1;
      if (e_we) m_push++;
      if (e_re) m_pop++;
    end
    chk_state(tag);
  endtask

  typedef struct {
    bit c, p, q;
    bit we, re;
    int cnt, w, r, rnd, ovf, udf;
  } vec_t;

  vec_t tbl[11];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit swe, sre;
    int pp;

    // Hard-coded vectors, starting from reset. Fields:
    //   clr, push, pop | we, re | count, w, r, round, ovf, udf
    tbl[0]  = '{0,1,0, 1,0, 1,1,0,0,0,0};
    tbl[1]  = '{0,1,0, 1,0, 2,2,0,0,0,0};
    tbl[2]  = '{0,1,0, 1,0, 3,3,0,0,0,0};
    tbl[3]  = '{0,0,1, 0,1, 2,3,1,0,0,0};
    tbl[4]  = '{0,0,1, 0,1, 1,3,2,0,0,0};
    tbl[5]  = '{0,0,1, 0,1, 0,3,3,0,0,0};
    tbl[6]  = '{0,1,1, 1,0, 1,4,3,0,0,1};  // pop on empty, no read-through
    tbl[7]  = '{0,0,0, 0,0, 1,4,3,0,0,1};
    tbl[8]  = '{1,1,1, 0,0, 0,0,0,0,0,0};  // clear wins over push/pop
    tbl[9]  = '{0,0,1, 0,0, 0,0,0,0,0,1};
    tbl[10] = '{1,0,0, 0,0, 0,0,0,0,0,0};

    bus.Clear = 0; bus.Push = 0; bus.Pop = 0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_state("reset");
    rst = 1'b1;

    // Idle after reset.
    step(0, 0, 0, "idle", swe, sre);

    // Vector table.
    foreach (tbl[i]) begin
      string t;
      t = $sformatf("tbl%0d", i);
      step(tbl[i].c, tbl[i].p, tbl[i].q, t, swe, sre);
      chk({t, ".tw_we"},    int'(swe),           int'(tbl[i].we));
      chk({t, ".tw_re"},    int'(sre),           int'(tbl[i].re));
      chk({t, ".tw_cnt"},   int'(bus.Count),     tbl[i].cnt);
      chk({t, ".tw_w"},     int'(bus.W_Addr),    tbl[i].w);
      chk({t, ".tw_r"},     int'(bus.R_Addr),    tbl[i].r);
      chk({t, ".tw_rnd"},   int'(bus.Round),     tbl[i].rnd);
      chk({t, ".tw_ovf"},   int'(bus.Overflow),  tbl[i].ovf);
      chk({t, ".tw_udf"},   int'(bus.Underflow), tbl[i].udf);
      chk({t, ".tw_empty"}, int'(bus.Empty),     tbl[i].cnt == 0 ? 1 : 0);
    end

    // Fill to full, then push alone (rejected, overflow).
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, "fill", swe, sre);
    chk("fill.full_k",  int'(bus.Full),       1);
    chk("fill.round_k", int'(bus.Round),      1);
    chk("fill.w_k",     int'(bus.W_Addr),     0);
    chk("fill.cnt_k",   int'(bus.Count),      16);
    chk("fill.af_k",    int'(bus.AlmostFull), 1);
    step(0, 1, 0, "over", swe, sre);
    chk("over.we_k",  int'(swe),          0);
    chk("over.ovf_k", int'(bus.Overflow), 1);
    chk("over.cnt_k", int'(bus.Count),    16);

    // Stream at full: both pointers wrap on the same edge.
    for (int i = 0; i < DEPTH; i++) begin
      step(0, 1, 1, "stream", swe, sre);
      chk("stream.both_k", int'(swe & sre), 1);
    end
    chk("stream.cnt_k",   int'(bus.Count), 16);
    chk("stream.full_k",  int'(bus.Full),  1);
    chk("stream.round_k", int'(bus.Round), 1);

    // Write pointer wraps first, then the read pointer catches up.
    step(1, 0, 0, "clr", swe, sre);
    for (int i = 0; i < 8; i++) step(0, 1, 0, "lap_a", swe, sre);
    for (int i = 0; i < 2; i++) step(0, 0, 1, "lap_b", swe, sre);
    for (int i = 0; i < 9; i++) step(0, 1, 0, "lap_c", swe, sre);
    chk("lap.round_k", int'(bus.Round),  1);
    chk("lap.w_k",     int'(bus.W_Addr), 1);
    chk("lap.r_k",     int'(bus.R_Addr), 2);
    step(0, 1, 0, "lap_d", swe, sre);
    for (int i = 0; i < DEPTH; i++) step(0, 0, 1, "drain", swe, sre);
    chk("drain.round_k", int'(bus.Round),  0);
    chk("drain.empty_k", int'(bus.Empty),  1);
    chk("drain.r_k",     int'(bus.R_Addr), 2);

    // Asynchronous reset mid-fill. Check it before any clock edge arrives.
    step(1, 0, 0, "clr2", swe, sre);
    for (int i = 0; i < 7; i++) step(0, 1, 0, "mid", swe, sre);
    chk("mid.cnt_k", int'(bus.Count), 7);
    @(negedge clk);
    bus.Push = 0;
    #2 rst = 1'b0;
    #1 model_reset();
    chk_state("async_rst");
    chk("async_rst.cnt_k", int'(bus.Count), 0);
    @(negedge clk);
    rst = 1'b1;

    // Clear while full with a lone push: no strobe and no overflow.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, "refill", swe, sre);
    step(1, 1, 0, "clr_push", swe, sre);
    chk("clr_push.we_k",  int'(swe),          0);
    chk("clr_push.ovf_k", int'(bus.Overflow), 0);

    // Clear while empty with a pop: no underflow.
    step(1, 0, 1, "clr_pop", swe, sre);
    chk("clr_pop.udf_k", int'(bus.Underflow), 0);

    // Random traffic. Push/pop bias alternates to reach both full and empty.
    for (int i = 0; i < 600; i++) begin
      bit c, p, q;
      pp = ((i / 75) % 2 == 0) ? 80 : 25;
      c = ($urandom_range(63) == 0);
      p = ($urandom_range(99) < pp);
      q = ($urandom_range(99) < (100 - pp));
      step(c, p, q, "rnd", swe, sre);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
